// File: rtl/bus_rr_pkg.sv
// Shared types and constants for the round-robin bus router.
package bus_rr_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_DEF = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_PUSH} state_t;
endpackage

// File: rtl/bus_rr_lane.sv
// One bus: round-robin grant over source FIFOs, one-packet buffer, unicast/broadcast/drop delivery.
module bus_rr_lane
  import bus_rr_pkg::*;
#(
  parameter int drvrs = 4,
  parameter int pckg_sz = 32,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic [15:0]                     drop_cnt
);
  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  state_t             state, state_nxt;
  logic [PW-1:0]      rr_ptr, rr_ptr_nxt, grant, grant_nxt, sel, cand;
  logic [pckg_sz-1:0] pkt, pkt_nxt, cur_pkt, d_push_nxt;
  logic [ID_W-1:0]    dest;
  logic [drvrs-1:0]   mask, pop_nxt, push_nxt;
  logic [15:0]        drop_nxt;
  logic               done, done_nxt, found, is_bcast, is_uni, ready;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < drvrs; i++) begin
      cand = PW'((int'(rr_ptr) + i) % drvrs);
      if (!found && pndng[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // In POP the head word is still on D_pop, so delivery can be decided without a bubble.
  always_comb begin
    cur_pkt  = (state == ST_POP) ? D_pop[grant] : pkt;
    dest     = cur_pkt[pckg_sz-1 -: ID_W];
    is_bcast = (dest == broadcast);
    is_uni   = !is_bcast && (int'(dest) < drvrs);
    for (int i = 0; i < drvrs; i++)
      mask[i] = is_bcast ? (i != int'(grant)) : (is_uni && (int'(dest) == i));
    ready = ((full & mask) == '0);
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    pkt_nxt    = pkt;
    done_nxt   = done;
    pop_nxt    = '0;
    push_nxt   = '0;
    d_push_nxt = D_push;
    drop_nxt   = drop_cnt;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          grant_nxt    = sel;
          pop_nxt[sel] = 1'b1;
          state_nxt    = ST_POP;
        end
      end
      ST_POP: begin
        pkt_nxt   = cur_pkt;
        state_nxt = ST_PUSH;
        done_nxt  = 1'b1;
        if (!is_bcast && !is_uni) begin
          if (drop_cnt != 16'hFFFF) drop_nxt = drop_cnt + 16'd1;
        end else if (ready) begin
          push_nxt   = mask;
          d_push_nxt = cur_pkt;
        end else begin
          done_nxt = 1'b0;
        end
      end
      ST_PUSH: begin
        // done: the push (or drop) is already out this cycle, so release the bus.
        if (done) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = PW'((int'(grant) + 1) % drvrs);
        end else if (ready) begin
          push_nxt   = mask;
          d_push_nxt = pkt;
          done_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      pkt      <= '0;
      done     <= 1'b0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant    <= grant_nxt;
      pkt      <= pkt_nxt;
      done     <= done_nxt;
      pop      <= pop_nxt;
      push     <= push_nxt;
      D_push   <= d_push_nxt;
      drop_cnt <= drop_nxt;
    end
  end
endmodule

// File: rtl/bus_rr_router.sv
// Top: one independent round-robin lane per bus.
module bus_rr_router
  import bus_rr_pkg::*;
#(
  parameter int bits = 1,
  parameter int drvrs = 4,
  parameter int pckg_sz = 32,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [bits-1:0][drvrs-1:0]             pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  input  logic [bits-1:0][drvrs-1:0]             full,
  output logic [bits-1:0][drvrs-1:0]             pop,
  output logic [bits-1:0][drvrs-1:0]             push,
  output logic [bits-1:0][pckg_sz-1:0]           D_push,
  output logic [bits-1:0][15:0]                  drop_cnt
);
  for (genvar g = 0; g < bits; g++) begin : g_lane
    bus_rr_lane #(
      .drvrs(drvrs), .pckg_sz(pckg_sz), .broadcast(broadcast)
    ) u_lane (
      .clk(clk), .reset(reset),
      .pndng(pndng[g]), .D_pop(D_pop[g]), .full(full[g]),
      .pop(pop[g]), .push(push[g]), .D_push(D_push[g]), .drop_cnt(drop_cnt[g])
    );
  end
endmodule

// File: tb/tb_bus_rr_router.sv
// Bench: terminal FIFOs as queues, cycle-timestamp model of the router, directed scenarios.
module tb_bus_rr_router;
  localparam int B = 2;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [B-1:0][N-1:0]        pndng, full, pop, push;
  logic [B-1:0][N-1:0][W-1:0] D_pop;
  logic [B-1:0][W-1:0]        D_push;
  logic [B-1:0][15:0]         drop_cnt;

  bus_rr_router #(.bits(B), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
    .pop(pop), .push(push), .D_push(D_push), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] srcq [B][N][$];
  logic [N-1:0] pop_seen [B];
  int checks = 0, failures = 0, cyc = 0, n = 0;
  int gr[5], at[5], exp_gr[5];

  // model: per bus, the cycle its pop shows and the cycle its delivery shows
  bit           m_busy [B];
  int           m_src [B], m_ptr [B], m_pop_at [B], m_out_at [B], m_drops [B];
  logic [W-1:0] m_pkt [B], m_dpush [B];
  logic [N-1:0] e_pop [B], e_push [B];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_drop(input logic [W-1:0] p);
    logic [7:0] d;
    d = p[W-1 -: 8];
    return (d != 8'hFF) && (int'(d) >= N);
  endfunction

  function automatic logic [N-1:0] mask_of(input logic [W-1:0] p, input int src);
    logic [7:0] d;
    d = p[W-1 -: 8];
    if (d == 8'hFF) return ~(N'(1) << src);
    if (int'(d) < N) return N'(1) << d;
    return '0;
  endfunction

  task automatic refresh();
    for (int b = 0; b < B; b++)
      for (int t = 0; t < N; t++) begin
        pndng[b][t] = (srcq[b][t].size() > 0);
        D_pop[b][t] = (srcq[b][t].size() > 0) ? srcq[b][t][0] : '0;
      end
  endtask

  task automatic load(input int b, input int t, input logic [W-1:0] p);
    srcq[b][t].push_back(p);
    refresh();
  endtask

  task automatic model_reset();
    for (int b = 0; b < B; b++) begin
      m_busy[b] = 1'b0; m_ptr[b] = 0; m_drops[b] = 0; m_src[b] = 0;
      m_pop_at[b] = -10; m_out_at[b] = -10;
      m_pkt[b] = '0; m_dpush[b] = '0;
      e_pop[b] = '0; e_push[b] = '0; pop_seen[b] = '0;
    end
  endtask

  task automatic model_step();
    for (int b = 0; b < B; b++) begin
      if (!m_busy[b]) begin
        bit hit = 1'b0;
        for (int i = 0; i < N; i++) begin
          int t = (m_ptr[b] + i) % N;
          if (!hit && srcq[b][t].size() > 0) begin hit = 1'b1; m_src[b] = t; end
        end
        if (hit) begin m_busy[b] = 1'b1; m_pop_at[b] = cyc; m_out_at[b] = -1; end
      end else if (m_out_at[b] < 0) begin
        if (cyc == m_pop_at[b] + 1)
          m_pkt[b] = (srcq[b][m_src[b]].size() > 0) ? srcq[b][m_src[b]][0] : '0;
        if (is_drop(m_pkt[b])) begin
          m_out_at[b] = cyc;
          if (m_drops[b] < 65535) m_drops[b]++;
        end else if ((full[b] & mask_of(m_pkt[b], m_src[b])) == '0) begin
          m_out_at[b] = cyc;
          m_dpush[b]  = m_pkt[b];
        end
      end else if (cyc == m_out_at[b] + 1) begin
        m_busy[b] = 1'b0;
        m_ptr[b]  = (m_src[b] + 1) % N;
      end
      e_pop[b]  = (m_busy[b] && m_pop_at[b] == cyc) ? (N'(1) << m_src[b]) : '0;
      e_push[b] = (m_busy[b] && m_out_at[b] == cyc) ? mask_of(m_pkt[b], m_src[b]) : '0;
    end
  endtask

  // Compare at negedge, advance model at posedge, update FIFOs just after.
  task automatic tick();
    @(negedge clk);
    for (int b = 0; b < B; b++) begin
      chk($sformatf("pop[%0d]@%0d", b, cyc), 64'(pop[b]), 64'(e_pop[b]));
      chk($sformatf("push[%0d]@%0d", b, cyc), 64'(push[b]), 64'(e_push[b]));
      chk($sformatf("D_push[%0d]@%0d", b, cyc), 64'(D_push[b]), 64'(m_dpush[b]));
      chk($sformatf("drop_cnt[%0d]@%0d", b, cyc), 64'(drop_cnt[b]), 64'(m_drops[b]));
      pop_seen[b] = pop[b];
    end
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    for (int b = 0; b < B; b++)
      for (int t = 0; t < N; t++)
        if (pop_seen[b][t] && srcq[b][t].size() > 0) void'(srcq[b][t].pop_front());
    refresh();
  endtask

  task automatic rst_chk(input string tag);
    for (int b = 0; b < B; b++) begin
      chk($sformatf("%s_pop[%0d]", tag, b), 64'(pop[b]), 64'(0));
      chk($sformatf("%s_push[%0d]", tag, b), 64'(push[b]), 64'(0));
      chk($sformatf("%s_dpush[%0d]", tag, b), 64'(D_push[b]), 64'(0));
      chk($sformatf("%s_drop[%0d]", tag, b), 64'(drop_cnt[b]), 64'(0));
    end
  endtask

  task automatic apply_reset(input string tag);
    #2 reset = 1'b0;
    #1 rst_chk(tag);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_gr = '{0, 1, 2, 3, 0};
    reset = 1'b0;
    full  = '0;
    model_reset();
    refresh();
    repeat (3) @(posedge clk);
    #1 rst_chk("init");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) tick();

    // single unicast: pop one cycle after pending, push one cycle after pop
    load(0, 1, 32'h020000AB);
    tick();
    chk("u_pop", 64'(pop[0]), 64'(4'b0010));
    chk("u_nopush", 64'(push[0]), 64'(0));
    tick();
    chk("u_push", 64'(push[0]), 64'(4'b0100));
    chk("u_data", 64'(D_push[0]), 64'(32'h020000AB));
    chk("u_pop_off", 64'(pop[0]), 64'(0));
    repeat (3) tick();

    // round-robin order from a fresh pointer, self-unicast to T0
    apply_reset("rr_rst");
    load(0, 0, 32'h00000000); load(0, 0, 32'h00000100);
    load(0, 1, 32'h00000001); load(0, 2, 32'h00000002); load(0, 3, 32'h00000003);
    n = 0;
    for (int k = 0; k < 40 && n < 5; k++) begin
      tick();
      if (pop[0] != '0) begin
        for (int t = 0; t < N; t++) if (pop[0][t]) gr[n] = t;
        at[n] = cyc;
        n++;
      end
    end
    chk("rr_count", 64'(n), 64'(5));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr_grant%0d", i), 64'(gr[i]), 64'(exp_gr[i]));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 64'(at[i] - at[i-1]), 64'(3));
    end
    repeat (4) tick();

    // broadcast on bus1 from T3
    load(1, 3, 32'hFF000001);
    tick();
    chk("bc_pop", 64'(pop[1]), 64'(4'b1000));
    tick();
    chk("bc_push", 64'(push[1]), 64'(4'b0111));
    chk("bc_data", 64'(D_push[1]), 64'(32'hFF000001));
    repeat (3) tick();

    // backpressure: dest 2 full for 5 cycles; T3 waits its turn
    full[0][2] = 1'b1;
    load(0, 1, 32'h02001234); load(0, 3, 32'h03000055);
    tick();
    chk("bp_pop", 64'(pop[0]), 64'(4'b0010));
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("bp_hold_push%0d", k), 64'(push[0]), 64'(0));
      chk($sformatf("bp_hold_pop%0d", k), 64'(pop[0]), 64'(0));
    end
    full[0][2] = 1'b0;
    tick();
    chk("bp_push", 64'(push[0]), 64'(4'b0100));
    chk("bp_data", 64'(D_push[0]), 64'(32'h02001234));
    chk("bp_nopop", 64'(pop[0]), 64'(0));
    tick();
    chk("bp_idle_pop", 64'(pop[0]), 64'(0));
    tick();
    chk("bp_next_pop", 64'(pop[0]), 64'(4'b1000));
    repeat (4) tick();

    // drop on bus0 while bus1 delivers normally
    chk("drop_before", 64'(drop_cnt[0]), 64'(0));
    load(0, 0, 32'h07000000); load(1, 0, 32'h0100BEEF);
    tick();
    chk("drop_pop0", 64'(pop[0]), 64'(4'b0001));
    chk("drop_pop1", 64'(pop[1]), 64'(4'b0001));
    tick();
    chk("drop_cnt0", 64'(drop_cnt[0]), 64'(1));
    chk("drop_nopush", 64'(push[0]), 64'(0));
    chk("drop_b1_push", 64'(push[1]), 64'(4'b0010));
    chk("drop_b1_data", 64'(D_push[1]), 64'(32'h0100BEEF));
    chk("drop_cnt1", 64'(drop_cnt[1]), 64'(0));
    repeat (3) tick();

    // reset while a push is on the bus; pointer returns to T0
    load(0, 2, 32'h01000077);
    tick();
    chk("rp_pop", 64'(pop[0]), 64'(4'b0100));
    tick();
    chk("rp_push", 64'(push[0]), 64'(4'b0010));
    apply_reset("rp_rst");
    load(0, 3, 32'h02000013); load(0, 0, 32'h02000010);
    tick();
    chk("rp_first_grant", 64'(pop[0]), 64'(4'b0001));
    chk("rp_lost", 64'(push[0]), 64'(0));
    tick();
    chk("rp_push2", 64'(push[0]), 64'(4'b0100));
    chk("rp_data2", 64'(D_push[0]), 64'(32'h02000010));
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
